// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared RS-232 definitions: state encoding, parity modes, divider helper
package rs232_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Integer clocks per bit, truncated; callers must keep the result >= 2.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic parity_of(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/rs232_tx_baud_gen.sv
// rtl/rs232_tx_baud_gen.sv - bit-period counter with clear and end-of-period tick
module baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] count;

  // Tick is decoded from the count so it lines up with the last clock of the period.
  assign tick = (count == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/rs232_tx.sv
// rtl/rs232_tx.sv - button/strobe triggered asynchronous serial transmitter
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  state_t     state;
  logic [7:0] shreg;
  logic       par_bit;
  logic [2:0] idx;
  logic       btn_q;
  logic       req;
  logic       tick;

  assign req = start | (btn & ~btn_q);

  baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state == ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      par_bit <= 1'b0;
      idx     <= '0;
      // High so a button already held through reset is not seen as a press.
      btn_q   <= 1'b1;
    end else begin
      btn_q <= btn;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            shreg   <= data_in;
            par_bit <= parity_of(data_in, PARITY);
            tx      <= 1'b0;
            busy    <= 1'b1;
            idx     <= '0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx    <= shreg[0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (idx == 3'd7) begin
              idx <= '0;
              if (PARITY != PAR_NONE) begin
                tx    <= par_bit;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              // Next bit is driven from the pre-shift word so tx stays registered.
              tx    <= shreg[1];
              shreg <= shreg >> 1;
              idx   <= idx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (idx == 3'(STOP_BITS - 1)) begin
              idx   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx.sv
// tb/tb_rs232_tx.sv - self-checking bench for rs232_tx across four parity/stop configurations
module tb_rs232_tx;

  localparam int DIV_T = 10;
  localparam int PARS  [4] = '{0, 1, 2, 1};
  localparam int STOPS [4] = '{1, 1, 1, 2};

  logic       clk;
  logic [3:0] rst, btn, start, tx, busy, done;
  logic [7:0] data_in [4];

  int n_cmp  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    rs232_tx #(
      .CLK_HZ   (1_000_000),
      .BAUD     (100_000),
      .PARITY   (PARS[g]),
      .STOP_BITS(STOPS[g])
    ) dut (
      .clk    (clk),
      .rst    (rst[g]),
      .btn    (btn[g]),
      .start  (start[g]),
      .data_in(data_in[g]),
      .tx     (tx[g]),
      .busy   (busy[g]),
      .done   (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: kk = clocks since the accept edge (-1 when no frame), md = latched byte.
  int         kk [4];
  logic [7:0] md [4];
  logic [3:0] bp;
  bit   [3:0] chk;
  int         done_cnt [4] = '{0, 0, 0, 0};

  function automatic int flen(input int i);
    return (9 + ((PARS[i] != 0) ? 1 : 0) + STOPS[i]) * DIV_T;
  endfunction

  function automatic logic frame_bit(input int i, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return md[i][j-1];
    if (j == 9 && PARS[i] != 0) return (PARS[i] == 2) ? ~(^md[i]) : (^md[i]);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst[i]) begin
        kk[i]  <= -1;
        bp[i]  <= 1'b1;
        chk[i] <= 1'b1;
      end else begin
        bp[i] <= btn[i];
        if ((start[i] | (btn[i] & ~bp[i])) && (kk[i] < 0 || kk[i] >= flen(i))) begin
          kk[i] <= 0;
          md[i] <= data_in[i];
        end else if (kk[i] >= 0 && kk[i] < flen(i)) begin
          kk[i] <= kk[i] + 1;
        end else begin
          kk[i] <= -1;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic e_tx, e_busy, e_done;
    for (int i = 0; i < 4; i++) begin
      if (chk[i]) begin
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        if (kk[i] >= 0 && kk[i] < flen(i)) begin
          e_tx   = frame_bit(i, kk[i] / DIV_T);
          e_busy = 1'b1;
        end else if (kk[i] == flen(i)) begin
          e_done = 1'b1;
        end
        n_cmp++;
        if ({tx[i], busy[i], done[i]} !== {e_tx, e_busy, e_done}) begin
          n_fail++;
          $display("FAIL model_inst%0d t=%0t: tx/busy/done got %b%b%b want %b%b%b",
                   i, $time, tx[i], busy[i], done[i], e_tx, e_busy, e_done);
        end
        if (done[i] === 1'b1) done_cnt[i]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Launches a frame and checks every bit mid-period plus the exact done cycle.
  task automatic check_frame(input int i, input logic [7:0] d, input int nb,
                             input logic [11:0] pat, input string tag);
    data_in[i] = d;
    start[i]   = 1'b1;
    step(1);
    start[i]   = 1'b0;
    check({tag, "_fall_tx"}, 32'(tx[i]), 32'd0);
    check({tag, "_fall_busy"}, 32'(busy[i]), 32'd1);
    for (int j = 0; j < nb; j++) begin
      step((j == 0) ? 5 : 10);
      check($sformatf("%s_bit%0d", tag, j), 32'(tx[i]), 32'(pat[j]));
    end
    step(4);
    check({tag, "_predone"}, 32'({busy[i], done[i]}), 32'b10);
    step(1);
    check({tag, "_done"}, 32'({busy[i], done[i]}), 32'b01);
    step(1);
    check({tag, "_done_1cyc"}, 32'(done[i]), 32'd0);
  endtask

  int c0;

  initial begin
    rst = 4'hF; btn = 4'hF; start = 4'h0;
    for (int i = 0; i < 4; i++) data_in[i] = 8'h00;
    step(3);
    rst = 4'h0;

    // Button held through reset must not fire; a later press sends one frame.
    step(30);
    check("s2_no_frame_busy", 32'(busy), 32'h0);
    check("s2_no_frame_done", 32'(done_cnt[0]), 32'd0);
    btn = 4'h0;
    step(3);
    btn[0] = 1'b1;
    step(1);
    check("s2_press_tx", 32'(tx[0]), 32'd0);
    step(150);
    check("s2_one_frame", 32'(done_cnt[0]), 32'd1);
    btn[0] = 1'b0;
    step(5);

    check_frame(0, 8'h55, 10, 12'b001010101010, "s1_55");
    check_frame(1, 8'h07, 11, 12'b011000001110, "s3_even");
    check_frame(2, 8'h07, 11, 12'b010000001110, "s3_odd");
    check_frame(3, 8'h07, 12, 12'b111000001110, "s3_stop2");

    // Mid-frame start and data change are ignored; start on the done cycle chains.
    data_in[0] = 8'hA3; start[0] = 1'b1; step(1); start[0] = 1'b0;
    step(35);
    data_in[0] = 8'hFF; start[0] = 1'b1; step(1); start[0] = 1'b0;
    step(9);
    check("s4_bit3_kept", 32'(tx[0]), 32'd0);
    step(55);
    check("s4_done", 32'({tx[0], done[0]}), 32'b11);
    data_in[0] = 8'h3C; start[0] = 1'b1; step(1); start[0] = 1'b0;
    check("s4_chain_fall", 32'({tx[0], busy[0]}), 32'b01);
    c0 = done_cnt[0];
    step(100);
    check("s4_chain_done", 32'(done[0]), 32'd1);
    step(150);
    check("s4_no_extra", 32'(done_cnt[0]), 32'(c0 + 1));

    // Reset at clock 45 of a frame aborts it without a done pulse.
    data_in[0] = 8'h96; start[0] = 1'b1; step(1); start[0] = 1'b0;
    step(44);
    rst[0] = 1'b1;
    step(1);
    check("s5_abort", 32'({tx[0], busy[0]}), 32'b10);
    rst[0] = 1'b0;
    c0 = done_cnt[0];
    step(120);
    check("s5_no_done", 32'(done_cnt[0]), 32'(c0));
    check_frame(0, 8'h55, 10, 12'b001010101010, "s5_clean");

    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) begin
        start[i] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 29) == 0) btn[i] = ~btn[i];
        if ($urandom_range(0, 9) == 0) data_in[i] = 8'($urandom);
        rst[i] = ($urandom_range(0, 1999) == 0);
      end
      step(1);
    end
    rst = 4'h0; start = 4'h0; btn = 4'h0;
    step(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232_tx.md
Name: rs232_tx

Overview:
- Serial transmitter stage sitting directly downstream of the push-button debouncer in the RS-232 lab.
- Consumes the debounced button level and an 8-bit data word (from switches).
- On a press (rising edge of the debounced level) or on an explicit start strobe, sends one asynchronous frame on the TX line: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
- Reports busy/done to the surrounding control logic.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s; localparam DIV = CLK_HZ/BAUD (integer, truncated), must be >= 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits (1 or 2 only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- btn  in  1  debounced button level; rising edge requests a transmit.
- start  in  1  single-cycle transmit request strobe, OR-ed with the btn rising edge.
- data_in  in  8  byte to send; sampled only on the accept cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  high from the cycle after accept until the frame ends.
- done  out  1  one-cycle pulse when the last stop bit period completes.

Behaviour:
- Reset values: tx = 1, busy = 0, done = 0, state = IDLE, baud counter = 0, bit index = 0, btn_q = 1.
  - btn_q resets to 1 so a button held through reset does not fire a request.
- Edge detect: btn_q <= btn every cycle; req = start | (btn & ~btn_q).
- Accept: req sampled while state == IDLE.
  - Latch data_in into shift register, compute parity bit, go to START.
  - req in any other state is dropped, not queued.
  - A btn edge during a frame is lost.
- All outputs are registered.
  - tx goes low on the cycle after accept.
  - busy rises on the same cycle as tx falls.
- States: IDLE -> START -> DATA -> (PARITY if PARITY != 0) -> STOP -> IDLE.
- Bit timing: each bit period lasts exactly DIV clocks.
  - Baud counter counts 0..DIV-1; the state/bit advances when the counter reaches DIV-1, and the counter wraps to 0.
  - Counter is held at 0 in IDLE.
- DATA: bit index 0..7; tx = shift register bit 0; shift right at each period end; leave after index 7.
- PARITY: even = XOR of the 8 bits; odd = inverted XOR.
- STOP: tx = 1 for STOP_BITS*DIV clocks, then IDLE.
  - In the first IDLE cycle: done = 1 for one cycle, busy = 0.
  - A req in that same cycle is accepted, giving back-to-back frames with no idle gap beyond that single cycle.
- Frame length: (1 + 8 + (PARITY != 0) + STOP_BITS) * DIV clocks, measured from the tx falling edge to the done pulse.
- Reset mid-frame aborts the frame.
  - tx = 1 and busy = 0 on the cycle after rst is sampled.
  - No done pulse is generated.
- Simultaneous start and btn edge count as a single request.
- data_in changes during a frame have no effect.

Decomposition:
- Shared package (rs232_pkg):
  - state enum encoding: IDLE, START, DATA, PARITY, STOP.
  - parity mode constants: PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2.
  - function computing DIV from CLK_HZ/BAUD; the future rs232_rx reuses all of these.
- One natural sub-module, baud_gen:
  - DIV-parameterised counter with a clear input and a one-cycle tick output at count DIV-1.
  - The receiver can share it.

Test Plan:
- Bench parameters: CLK_HZ = 1_000_000, BAUD = 100_000 (DIV = 10), PARITY = 0, STOP_BITS = 1.
- Scenario 1: start pulse with data_in = 0x55.
  - tx low 10 clocks, then bits 1,0,1,0,1,0,1,0, each 10 clocks, then high 10 clocks.
  - done pulses exactly 100 clocks after the tx falling edge; busy high throughout.
- Scenario 2: btn held high through reset release, then btn low and high again.
  - No frame after reset; exactly one frame after the later rising edge.
- Scenario 3: PARITY = 1 with data 0x07, then PARITY = 2 with data 0x07.
  - Parity bit is 1 for even, 0 for odd; frame is 110 clocks; STOP_BITS = 2 adds 10 clocks.
- Scenario 4: start asserted mid-frame and data_in changed mid-frame.
  - Transmitted bits are unchanged and no second frame follows.
  - start on the done cycle launches the next frame, with tx falling one clock later.
- Scenario 5: rst asserted at clock 45 of a frame.
  - tx = 1, busy = 0 next cycle, no done pulse.
  - A new start afterwards produces a clean 100-clock frame.
